fp_addsub_arbiter: RTL and testbench

- Shares one registered single-precision FP add/sub unit between NUM_REQ requesters, e.g. integer-pipe FP issue and a microcode sequencer.
- Arbitration is round-robin with valid/ready handshakes on both the request side and the response side.
- Only one operation is in flight at a time.
- The block drives the unit's operand and op inputs, waits the unit's fixed latency, captures the result and returns it to the granted requester.

---
 rtl/fp_addsub_arbiter.sv | 145 ++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one registered
// single-precision add/sub unit, one operation in flight.
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int FPU_LAT = 1,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [31:0]          resp_result,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [1:0]           fpu_op,
    input  logic [31:0]          fpu_result,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_nx;
    logic           found;
    logic           resp_fire;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_op;
    logic [3:0]     wait_cnt;

    // Round-robin search: rr_ptr upward first, then wrap to 0
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && IDW'(i) >= rr_ptr) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
    end

    // Operand mux for the winning requester; only op bit 0 is used
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == winner) begin
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*2];
            end
        end
    end

    assign ptr_nx = (grant_id == IDW'(NUM_REQ - 1)) ? '0
                                                    : grant_id + IDW'(1);
    assign busy   = (state != IDLE);

    // Next state plus the combinational ready/valid handshake bits
    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx = EXEC;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (IDW'(i) == winner) req_ready[i] = 1'b1;
                end
            end
            EXEC: begin
                if (wait_cnt == 4'd0) state_nx = RESP;
            end
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (IDW'(i) == grant_id) begin
                        resp_valid[i] = 1'b1;
                        resp_fire     = resp_ready[i];
                    end
                end
                if (resp_fire) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Operand capture, latency countdown, result capture, pointer advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_op      <= '0;
            resp_result <= '0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        fpu_a    <= sel_a;
                        fpu_b    <= sel_b;
                        fpu_op   <= {1'b0, sel_op};
                        grant_id <= winner;
                        wait_cnt <= 4'(FPU_LAT);
                    end
                end
                EXEC: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    else                  resp_result <= fpu_result;
                end
                RESP: begin
                    if (resp_fire) rr_ptr <= ptr_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed vectors against two instances,
// FPU_LAT=1 and FPU_LAT=3, each fed by a behavioural FP add/sub model.
module tb_fp_addsub_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel3 = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_op = '0;
    logic [1:0]  resp_ready = 2'b11;

    logic [1:0]  rv1, rr1, pv1, rv3, rr3, pv3;
    logic [31:0] res1, fa1, fb1, fr1, res3, fa3, fb3, fr3;
    logic [1:0]  fo1, fo3;
    logic        busy1, busy3;
    logic [0:0]  gid1, gid3;

    logic [1:0]  o_req_ready, o_resp_valid, o_fpu_op;
    logic [31:0] o_resp_result, o_fpu_a;
    logic        o_busy;
    logic [0:0]  o_grant;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign rv1 = sel3 ? 2'b00 : req_valid;
    assign rv3 = sel3 ? req_valid : 2'b00;
    assign o_req_ready   = sel3 ? rr3 : rr1;
    assign o_resp_valid  = sel3 ? pv3 : pv1;
    assign o_resp_result = sel3 ? res3 : res1;
    assign o_fpu_a       = sel3 ? fa3 : fa1;
    assign o_fpu_op      = sel3 ? fo3 : fo1;
    assign o_busy        = sel3 ? busy3 : busy1;
    assign o_grant       = sel3 ? gid3 : gid1;

    fp_addsub_arbiter #(.NUM_REQ(2), .FPU_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(rr1),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(pv1), .resp_ready(resp_ready), .resp_result(res1),
        .fpu_a(fa1), .fpu_b(fb1), .fpu_op(fo1), .fpu_result(fr1),
        .busy(busy1), .grant_id(gid1)
    );

    fp_addsub_arbiter #(.NUM_REQ(2), .FPU_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_ready(rr3),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(pv3), .resp_ready(resp_ready), .resp_result(res3),
        .fpu_a(fa3), .fpu_b(fb3), .fpu_op(fo3), .fpu_result(fr3),
        .busy(busy3), .grant_id(gid3)
    );

    function automatic real s2r(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2s(input real v);
        real  r;
        int   e;
        logic s;
        logic [22:0] f;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        f = 23'($rtoi((r - 1.0) * 8388608.0 + 0.5));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [1:0] op);
        if (op[0]) return r2s(s2r(a) - s2r(b));
        return r2s(s2r(a) + s2r(b));
    endfunction

    logic [31:0] p1;
    logic [31:0] p3 [3];

    always @(posedge clk or posedge reset) begin
        if (reset) p1 <= '0;
        else       p1 <= fadd(fa1, fb1, fo1);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p3[0] <= '0; p3[1] <= '0; p3[2] <= '0;
        end else begin
            p3[0] <= fadd(fa3, fb3, fo3);
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end

    assign fr1 = p1;
    assign fr3 = p3[2];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lat;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [1:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  op1;
        int          grant;
        logic [31:0] res;
        logic [1:0]  fop;
    } vec_t;

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (o_req_ready != 2'b00) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        bit ok;
        int n;
        @(negedge clk);
        sel3      = (v.lat == 3);
        req_a     = {v.a1, v.a0};
        req_b     = {v.b1, v.b0};
        req_op    = {v.op1, v.op0};
        req_valid = v.valid;
        wait_ready(ok);
        if (!ok) begin
            check({tag, " ready_timeout"}, 32'd0, 32'd1);
            req_valid = '0;
            return;
        end
        check({tag, " req_ready"}, 32'(o_req_ready), 32'(onehot(v.grant)));
        @(negedge clk);
        req_valid = '0;
        n = 1;
        check({tag, " grant_id"}, 32'(o_grant), 32'(v.grant));
        check({tag, " fpu_op"}, 32'(o_fpu_op), 32'(v.fop));
        check({tag, " fpu_a"}, o_fpu_a, (v.grant == 1) ? v.a1 : v.a0);
        while (o_resp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(v.lat + 2));
        check({tag, " resp_valid"}, 32'(o_resp_valid), 32'(onehot(v.grant)));
        check({tag, " result"}, o_resp_result, v.res);
        @(negedge clk);
        check({tag, " idle"}, 32'(o_busy), 32'd0);
    endtask

    vec_t vt [8];

    initial begin
        bit   ok;
        vec_t v;

        vt[0] = '{1, 2'b11, 32'h40400000, 32'h3F800000, 2'b01,
                  32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h40000000, 2'b01};
        vt[1] = '{1, 2'b10, 32'h40400000, 32'h3F800000, 2'b01,
                  32'h3F800000, 32'h3F800000, 2'b00, 1, 32'h40000000, 2'b00};
        vt[2] = '{1, 2'b11, 32'h3F800000, 32'h40000000, 2'b00,
                  32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h40400000, 2'b00};
        vt[3] = '{1, 2'b01, 32'h3F800000, 32'h40000000, 2'b00,
                  32'h0, 32'h0, 2'b00, 0, 32'h40400000, 2'b00};
        vt[4] = '{1, 2'b10, 32'h0, 32'h0, 2'b00,
                  32'h40000000, 32'h3F800000, 2'b10, 1, 32'h40400000, 2'b00};
        vt[5] = '{1, 2'b11, 32'h40400000, 32'h3F800000, 2'b11,
                  32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h40000000, 2'b01};
        vt[6] = '{1, 2'b11, 32'h3F800000, 32'h3F800000, 2'b00,
                  32'h40800000, 32'h40400000, 2'b01, 1, 32'h3F800000, 2'b01};
        vt[7] = '{3, 2'b01, 32'h40400000, 32'h3F800000, 2'b11,
                  32'h0, 32'h0, 2'b00, 0, 32'h40000000, 2'b01};

        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy1), 32'd0);
        check("rst req_ready", 32'(rr1), 32'd0);
        check("rst resp_valid", 32'(pv1), 32'd0);
        check("rst grant_id", 32'(gid1), 32'd0);
        check("rst fpu_a", fa1, 32'd0);
        check("rst fpu_op", 32'(fo1), 32'd0);
        check("rst result", res1, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vt[i]);

        // Fairness: both requesters continuously valid
        @(negedge clk);
        sel3      = 1'b0;
        req_a     = {32'h3F800000, 32'h3F800000};
        req_b     = {32'h3F800000, 32'h3F800000};
        req_op    = 4'b0000;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_ready(ok);
            if (!ok) begin
                check("fair timeout", 32'd0, 32'd1);
                break;
            end
            check($sformatf("fair grant%0d", i), 32'(rr1),
                  32'(onehot(i % 2)));
            @(negedge clk);
        end
        req_valid = '0;
        for (int k = 0; k < 20 && busy1; k++) @(negedge clk);
        check("fair drained", 32'(busy1), 32'd0);

        // Backpressure: response held, requester 1 waits, its resp_ready ignored
        resp_ready = 2'b10;
        req_a      = {32'h3F800000, 32'h3F800000};
        req_b      = {32'h3F800000, 32'h40000000};
        req_valid  = 2'b01;
        wait_ready(ok);
        check("bp ready", 32'(rr1), 32'h1);
        @(negedge clk);
        req_valid = 2'b10;
        for (int k = 0; k < 20 && pv1 == 2'b00; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp resp_valid", 32'(pv1), 32'h1);
            check("bp result", res1, 32'h40400000);
            check("bp req_ready", 32'(rr1), 32'h0);
            check("bp grant", 32'(gid1), 32'h0);
            @(negedge clk);
        end
        resp_ready = 2'b11;
        @(negedge clk);
        #1;
        check("bp next grant", 32'(rr1), 32'h2);
        req_valid = '0;

        // Reset one cycle after the handshake abandons the operation
        @(negedge clk);
        req_valid = 2'b10;
        wait_ready(ok);
        check("rst_mid ready", 32'(rr1), 32'h2);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy1), 32'd0);
        check("rst_mid resp_valid", 32'(pv1), 32'd0);
        check("rst_mid fpu_a", fa1, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_mid no resp", 32'(pv1), 32'd0);
        end
        v = '{1, 2'b11, 32'h3F800000, 32'h40000000, 2'b00,
              32'h40400000, 32'h3F800000, 2'b01, 0, 32'h40400000, 2'b00};
        run_txn("after_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
